// File: rtl/axis_rxd_fifo.sv
// ---------------------------------------------------------------------------
// axis_rxd_fifo
//
// Elastic buffer between the reconfigurable partition's 512-bit AXI4-Stream
// result output and the DMA S2MM stream input. The partition reacts to
// s_tready one cycle late, so s_tready drops early (SLACK free entries left)
// and late beats are still written into the remaining space. A beat that
// arrives while the FIFO is full is dropped and sets the sticky overflow flag.
//
// Optional feature: define AXIS_RXD_FIFO_STORE_FWD_EN for store-and-forward
// mode. m_tvalid is then only raised once a complete packet is buffered, or
// when the FIFO is full without a complete packet (oversize-packet release).
//
// Ports:
//   clk50mhz_0            in   clock, rising edge
//   peripheral_aresetn_0  in   asynchronous active-low reset
//   s_tdata/s_tlast       in   slave beat from partition RXD
//   s_tvalid              in   slave beat valid
//   s_tready              out  registered slave ready (early-deasserting)
//   m_tdata/m_tlast       out  master beat to DMA S2MM (head entry)
//   m_tvalid              out  master beat valid
//   m_tready              in   master ready
//   level                 out  number of stored entries
//   overflow              out  sticky, set when a beat is dropped
// ---------------------------------------------------------------------------
module axis_rxd_fifo #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 16,
    parameter int SLACK  = 2
) (
    input  logic                     clk50mhz_0,
    input  logic                     peripheral_aresetn_0,
    input  logic [DATA_W-1:0]        s_tdata,
    input  logic                     s_tlast,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic [DATA_W-1:0]        m_tdata,
    output logic                     m_tlast,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH) + 1;
    localparam int IW = AW - 1;

    // Each entry is {tlast, tdata}
    logic [DATA_W:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] level_d;
    logic          s_tready_q, s_tready_d;
    logic          overflow_q, overflow_d;

    logic          full;
    logic          empty;
    logic          valid;
    logic          rd_en;
    logic          wr_en;
    logic [DATA_W:0] head;

`ifdef AXIS_RXD_FIFO_STORE_FWD_EN
    logic [AW-1:0] pkt_cnt_q, pkt_cnt_d;
`endif

    always_comb begin
        full  = (wr_ptr_q[AW-1] != rd_ptr_q[AW-1]) &&
                (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
        empty = (wr_ptr_q == rd_ptr_q);
        head  = mem_q[rd_ptr_q[IW-1:0]];

`ifdef AXIS_RXD_FIFO_STORE_FWD_EN
        // Full with no complete packet releases the head so an oversize
        // packet cannot deadlock the buffer.
        valid = !empty && ((pkt_cnt_q != '0) || full);
`else
        valid = !empty;
`endif

        rd_en = valid && m_tready;
        // s_tready is deliberately ignored: late beats land in the slack space.
        // A read in the same cycle frees the slot, so a full FIFO still accepts.
        wr_en = s_tvalid && (!full || rd_en);

        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = wr_ptr_d - rd_ptr_d;

        s_tready_d = (AW'(DEPTH) - level_d) > AW'(SLACK);
        overflow_d = overflow_q || (s_tvalid && full && !rd_en);

`ifdef AXIS_RXD_FIFO_STORE_FWD_EN
        pkt_cnt_d = pkt_cnt_q;
        if ((wr_en && s_tlast) && !(rd_en && head[DATA_W])) begin
            pkt_cnt_d = pkt_cnt_q + AW'(1);
        end else if (!(wr_en && s_tlast) && (rd_en && head[DATA_W])) begin
            pkt_cnt_d = pkt_cnt_q - AW'(1);
        end
`endif
    end

    always_ff @(posedge clk50mhz_0 or negedge peripheral_aresetn_0) begin
        if (!peripheral_aresetn_0) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            s_tready_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            s_tready_q <= s_tready_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef AXIS_RXD_FIFO_STORE_FWD_EN
    always_ff @(posedge clk50mhz_0 or negedge peripheral_aresetn_0) begin
        if (!peripheral_aresetn_0) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end
`endif

    // Storage needs no reset: stale contents are unreachable once the
    // pointers are cleared, and the outputs are masked by valid.
    always_ff @(posedge clk50mhz_0) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[IW-1:0]] <= {s_tlast, s_tdata};
        end
    end

    always_comb begin
        m_tvalid = valid;
        m_tdata  = valid ? head[DATA_W-1:0] : '0;
        m_tlast  = valid ? head[DATA_W] : 1'b0;
        s_tready = s_tready_q;
        overflow = overflow_q;
        level    = wr_ptr_q - rd_ptr_q;
    end

endmodule

// File: doc/axis_rxd_fifo.md
# axis_rxd_fifo

Buffers the 512-bit AXI4-Stream result output of the reconfigurable partition before it reaches the DMA S2MM stream input. The partition's output stage is registered and responds to `tready` one cycle late. This block therefore absorbs in-flight beats using an early-deasserting `s_tready` with configurable slack. It presents a clean, fully backpressured master stream downstream. It also flags any beat lost to overflow.

## Interface
Parameters:
- `DATA_W`, 512, stream data width in bits.
- `DEPTH`, 16, number of FIFO entries; must be a power of two and ≥ 4.
- `SLACK`, 2, free-entry threshold for `s_tready`; must be ≥ 1 and < `DEPTH`.

Ports:
- `clk50mhz_0` in 1: sole clock; all logic is on its rising edge.
- `peripheral_aresetn_0` in 1: reset; asynchronous assert, active-low.
- `s_tdata` in `DATA_W`: slave data, driven by the partition RXD output.
- `s_tlast` in 1: slave end of packet.
- `s_tvalid` in 1: slave beat valid.
- `s_tready` out 1: slave ready, returned to the partition RXD ready.
- `m_tdata` out `DATA_W`: master data to DMA S2MM.
- `m_tlast` out 1: master end of packet.
- `m_tvalid` out 1: master beat valid.
- `m_tready` in 1: master ready.
- `level` out `$clog2(DEPTH)+1`: current number of stored entries.
- `overflow` out 1: sticky flag; set when a beat is dropped.

## Operation
- Storage: circular buffer of `DEPTH` entries, each `{tlast, tdata}`. Write and read pointers are `$clog2(DEPTH)+1` bits wide. The MSB distinguishes full from empty; pointers wrap naturally.
- Write rule: a beat is written whenever `s_tvalid`=1 and the FIFO is not full. `s_tready` is ignored for this decision, so late beats from the partition are accepted into the slack space.
- Overflow: if `s_tvalid`=1 while full, the beat is dropped and `overflow` is set. `overflow` clears only on reset.
- `s_tready` is registered. It is 1 when free entries after this cycle's update exceed `SLACK`, and 0 otherwise.
- Read rule: a read occurs when `m_tvalid`=1 and `m_tready`=1. `m_tdata`, `m_tlast` and `m_tvalid` are driven from the head entry.
- Stability: `m_tdata` and `m_tlast` hold stable while `m_tvalid`=1 and `m_tready`=0.
- Simultaneous write and read:
  - Allowed when the FIFO is full; the read frees the entry, the write is accepted, and `overflow` is not set.
  - When the FIFO is empty, the write is accepted and the read cannot occur, because `m_tvalid`=0.
- `level` equals write pointer minus read pointer. It is unchanged on a simultaneous write and read.
- Reset values: `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `s_tready`=0, `level`=0, `overflow`=0, both pointers 0.
- Reset mid-packet: all stored beats are discarded. No partial packet is emitted after reset releases.

## Timing
- `s_tready` rises in the first clock after reset deassertion.
- Cut-through latency: a beat written at edge N has `m_tvalid`=1 after edge N, i.e. one cycle, provided no earlier entries are queued.
- Throughput: one beat per cycle sustained in both directions.
- Free-entry threshold:
  - `s_tready` falls on the edge at which free entries become ≤ `SLACK`.
  - It rises on the edge at which free entries become > `SLACK`.
- Backpressure guarantee: with `SLACK` ≥ 2, the partition's one-cycle-late response never causes overflow.

## Configuration
- Macro: `AXIS_RXD_FIFO_STORE_FWD_EN`.
- Defined (store-and-forward mode):
  - A complete-packet counter is included. It increments on writing a `tlast`=1 beat and decrements on reading a `tlast`=1 beat; a simultaneous increment and decrement leaves it unchanged.
  - `m_tvalid` asserts only when the counter > 0, or when the FIFO is full with counter = 0. This oversize-packet release prevents deadlock.
- Undefined: pure cut-through, and the counter logic is absent.

## Test plan
- Single beat: reset, then one beat `s_tdata`=0x1234, `s_tlast`=1 with `m_tready`=1.
  - `m_tvalid`=1 exactly one cycle later with the same data and `tlast`.
  - `level` returns to 0.
- Stream with stall: DEPTH=16, SLACK=2, `m_tready`=0, 20 back-to-back beats valued 0..19. The source honours `s_tready` with one cycle of lag.
  - `s_tready` falls when `level`=14.
  - 15 beats are stored and `overflow` stays 0.
  - Releasing `m_tready` yields 0..14 in order.
- Forced overflow: source ignores `s_tready` and drives 17 beats into an empty FIFO with `m_tready`=0.
  - Beat 16 (value 16) is dropped and `overflow`=1.
  - Draining returns 0..15.
- Full plus simultaneous read/write: FIFO full, `m_tready`=1 and `s_tvalid`=1 for one cycle.
  - `level` stays 16 and `overflow` stays 0.
- Reset mid-packet: 5 beats queued, `peripheral_aresetn_0` pulsed low for half a cycle.
  - Outputs are immediately at reset values.
  - `m_tvalid` stays 0 until a new beat arrives.
- Store-and-forward (macro defined): 4-beat packet with `tlast` on beat 3.
  - `m_tvalid` stays 0 until the cycle after beat 3 is written.
  - A 17-beat packet is released once the FIFO fills.
